// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 Gaussian filter: image defaults,
// pixel width, kernel weights and the frame sequencer state encoding.
package gauss_pkg;

    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int PIX_W     = 8;

    // Kernel 1 2 1 / 2 4 2 / 1 2 1, normalised by a right shift of 4.
    localparam int KERN_SHIFT = 4;

    function automatic int unsigned kern_coef(input int unsigned r, input int unsigned c);
        return ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order row/column position counter with wrap and last-pixel flag.
module raster_counter
    import gauss_pkg::*;
#(
    parameter int COLS  = IMG_W_DEF,
    parameter int ROWS  = IMG_H_DEF,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(COLS - 1));
    assign row_end = (row == ROW_W'(ROWS - 1));
    assign last    = col_end && row_end;

    // The row wraps after the final pixel so the position is 0 between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/gauss_stream_ctrl.sv
// Frame sequencer for the 3x3 Gaussian datapath: tracks input/output raster
// positions, throttles the source and flags zero-padded kernel borders.
module gauss_stream_ctrl
    import gauss_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CNT_W = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     lb_wr_en,
    output logic [$clog2(IMG_W)-1:0] lb_wr_col,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic                     bord_top,
    output logic                     bord_bot,
    output logic                     bord_lft,
    output logic                     bord_rgt,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int LEAD_MAX = IMG_W + 2;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] lead;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] need_cnt;
    logic [COL_W-1:0] in_col;
    logic [ROW_W-1:0] in_row;
    logic [COL_W-1:0] out_col;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] need_col;
    logic [ROW_W-1:0] need_row;
    logic             in_last;
    logic             out_last;
    logic             in_hs;
    logic             out_hs;
    logic             clear;

    assign in_hs  = s_valid && s_ready;
    assign out_hs = m_valid && m_ready;
    assign clear  = (state == ST_IDLE) && start;

    raster_counter #(.COLS(IMG_W), .ROWS(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W)) u_in_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (in_hs),
        .col     (in_col),
        .row     (in_row),
        .last    (in_last)
    );

    raster_counter #(.COLS(IMG_W), .ROWS(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W)) u_out_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (out_hs),
        .col     (out_col),
        .row     (out_row),
        .last    (out_last)
    );

    // Accepted-pixel count is the raster index of the next input; it wraps to 0
    // after the last pixel, which only happens once the frame is in FLUSH.
    assign in_cnt = CNT_W'(in_row) * CNT_W'(IMG_W) + CNT_W'(in_col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            lead  <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                lead <= '0;
            end else begin
                case ({in_hs, out_hs})
                    2'b10:   lead <= lead + CNT_W'(1);
                    2'b01:   lead <= lead - CNT_W'(1);
                    default: lead <= lead;
                endcase
            end
        end
    end

    // Output (r,c) needs its bottom-right neighbour (clamped at the edges) in the line buffer.
    always_comb begin
        need_row = (out_row == ROW_W'(IMG_H - 1)) ? out_row : out_row + ROW_W'(1);
        need_col = (out_col == COL_W'(IMG_W - 1)) ? out_col : out_col + COL_W'(1);
        need_cnt = CNT_W'(need_row) * CNT_W'(IMG_W) + CNT_W'(need_col) + CNT_W'(1);
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                s_ready = (lead < CNT_W'(LEAD_MAX));
                m_valid = (in_cnt >= need_cnt);
                if (s_valid && s_ready && in_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                m_valid = 1'b1;
                if (m_ready && out_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign lb_wr_en  = in_hs;
    assign lb_wr_col = in_col;
    assign win_col   = out_col;
    assign win_row   = out_row;
    assign busy      = (state != ST_IDLE);

    // Flags are held low whenever there is no output pixel to describe.
    assign bord_top = m_valid && (out_row == '0);
    assign bord_bot = m_valid && (out_row == ROW_W'(IMG_H - 1));
    assign bord_lft = m_valid && (out_col == '0);
    assign bord_rgt = m_valid && (out_col == COL_W'(IMG_W - 1));

endmodule

// File: tb/tb_gauss_stream_ctrl.sv
// Scenario bench for gauss_stream_ctrl on a 4x4 frame, with a count-based
// reference model of which pixels may be accepted and emitted each cycle.
module tb_gauss_stream_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int CW = $clog2(N + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       s_valid;
    logic       m_ready;
    logic       s_ready;
    logic       m_valid;
    logic       lb_wr_en;
    logic [1:0] lb_wr_col;
    logic [1:0] win_col;
    logic [1:0] win_row;
    logic       bord_top;
    logic       bord_bot;
    logic       bord_lft;
    logic       bord_rgt;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    int basic_done_cyc = -1;
    logic [3:0] flag_rec [N];
    bit         flag_seen [N];

    gauss_stream_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .lb_wr_en   (lb_wr_en),
        .lb_wr_col  (lb_wr_col),
        .win_col    (win_col),
        .win_row    (win_row),
        .bord_top   (bord_top),
        .bord_bot   (bord_bot),
        .bord_lft   (bord_lft),
        .bord_rgt   (bord_rgt),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is active from start until its N-th output,
    // followed by one done cycle. Only counts of pixels in/out are kept.
    bit m_act   = 1'b0;
    bit m_donef = 1'b0;
    int m_in    = 0;
    int m_out   = 0;

    function automatic int thr(input int k);
        int r = k / W;
        int c = k % W;
        return ((r + 1 < H - 1) ? r + 1 : H - 1) * W + ((c + 1 < W - 1) ? c + 1 : W - 1) + 1;
    endfunction

    function automatic bit exp_sready();
        return m_act && (m_in < N) && ((m_in - m_out) < W + 2);
    endfunction

    function automatic bit exp_mvalid();
        return m_act && (m_out < N) && (m_in >= thr(m_out));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   <= 1'b0;
            m_donef <= 1'b0;
            m_in    <= 0;
            m_out   <= 0;
        end else if (!m_act && !m_donef) begin
            if (start) begin
                m_act <= 1'b1;
                m_in  <= 0;
                m_out <= 0;
            end
        end else begin
            m_donef <= 1'b0;
            if (exp_sready() && s_valid) m_in <= m_in + 1;
            if (exp_mvalid() && m_ready) begin
                m_out <= m_out + 1;
                if (m_out == N - 1) begin
                    m_act   <= 1'b0;
                    m_donef <= 1'b1;
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_ready, m_valid, lb_wr_en, frame_done, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=00000", {s_ready, m_valid, lb_wr_en, frame_done, busy});
        end
        checks++;
        if ({bord_top, bord_bot, bord_lft, bord_rgt} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=0000", {bord_top, bord_bot, bord_lft, bord_rgt});
        end
        checks++;
        if ({win_row, win_col, lb_wr_col} !== 6'b0) begin
            errors++; $display("FAIL reset_pos got=%b want=000000", {win_row, win_col, lb_wr_col});
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_ready, busy} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset got=%b want=00", {s_ready, busy});
        end
    endtask

    task automatic test_basic;
        int nin = 0, nout = 0, ndone = 0, six_cyc = -1, first_mv = -1, last_out = -1, done_cyc = -1, idx;
        s_valid = 1'b1; m_ready = 1'b1; start = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++; $display("FAIL basic_pre_start s_ready got=%b want=0", s_ready);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            checks++;
            if (m_valid !== exp_mvalid()) begin
                errors++; $display("FAIL basic_mvalid cyc=%0d got=%b want=%b", cyc, m_valid, exp_mvalid());
            end
            checks++;
            if (s_ready !== exp_sready()) begin
                errors++; $display("FAIL basic_sready cyc=%0d got=%b want=%b", cyc, s_ready, exp_sready());
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (lb_wr_en) begin
                nin++;
                if (nin == W + 2) six_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                idx = int'(win_row) * W + int'(win_col);
                flag_rec[idx]  = {bord_top, bord_bot, bord_lft, bord_rgt};
                flag_seen[idx] = 1'b1;
                nout++;
                last_out = cyc;
            end
            if (frame_done) begin
                ndone++;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        basic_done_cyc = done_cyc;
        checks++;
        if (first_mv !== six_cyc + 1) begin
            errors++; $display("FAIL basic_latency first_mv=%0d want=%0d", first_mv, six_cyc + 1);
        end
        checks++;
        if (nin !== N || nout !== N) begin
            errors++; $display("FAIL basic_counts in=%0d out=%0d want=%0d/%0d", nin, nout, N, N);
        end
        checks++;
        if (ndone !== 1 || done_cyc !== last_out + 1) begin
            errors++; $display("FAIL basic_done pulses=%0d at=%0d want=1 at %0d", ndone, done_cyc, last_out + 1);
        end
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_end got=%b want=0", busy);
        end
    endtask

    task automatic test_borders;
        int nflag = 0;
        logic [3:0] want;
        for (int k = 0; k < N; k++) begin
            want = {(k / W) == 0, (k / W) == H - 1, (k % W) == 0, (k % W) == W - 1};
            checks++;
            if (!flag_seen[k] || flag_rec[k] !== want) begin
                errors++; $display("FAIL border_flags idx=%0d seen=%b got=%b want=%b", k, flag_seen[k], flag_rec[k], want);
            end
            if (flag_rec[k] != 4'b0) nflag++;
        end
        checks++;
        if (flag_rec[3 * W + 3] !== 4'b0101) begin
            errors++; $display("FAIL border_33 got=%b want=0101", flag_rec[3 * W + 3]);
        end
        checks++;
        if (flag_rec[1 * W + 2] !== 4'b0000) begin
            errors++; $display("FAIL border_12 got=%b want=0000", flag_rec[1 * W + 2]);
        end
        checks++;
        if (nflag !== 12) begin
            errors++; $display("FAIL border_count got=%0d want=12", nflag);
        end
    endtask

    task automatic test_backpressure;
        int nin = 0, extra = 0;
        bit seen = 1'b0;
        s_valid = 1'b1; m_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (lb_wr_en) nin++;
            if (cyc >= 10) begin
                checks++;
                if ({s_ready, m_valid, win_row, win_col} !== 6'b010000) begin
                    errors++; $display("FAIL bp_hold cyc=%0d got s_ready=%b m_valid=%b row=%0d col=%0d want 0 1 0 0", cyc, s_ready, m_valid, win_row, win_col);
                end
                checks++;
                if ({bord_top, bord_bot, bord_lft, bord_rgt} !== 4'b1010) begin
                    errors++; $display("FAIL bp_flags cyc=%0d got=%b want=1010", cyc, {bord_top, bord_bot, bord_lft, bord_rgt});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (nin !== W + 2) begin
            errors++; $display("FAIL bp_inputs got=%0d want=%0d", nin, W + 2);
        end
        m_ready = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b1) begin
            errors++; $display("FAIL bp_release m_valid got=%b want=1", m_valid);
        end
        @(negedge clk);
        m_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (lb_wr_en) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra !== 1) begin
            errors++; $display("FAIL bp_one_more got=%0d want=1", extra);
        end
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            #1;
            if (frame_done) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_drain frame_done got=0 want=1");
        end
    endtask

    task automatic test_starved;
        int nin = 0, nout = 0, ndone = 0, max_lead = 0;
        bit order_ok = 1'b1, mv_idle = 1'b0;
        m_ready = 1'b1; s_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            s_valid = (cyc % 2 == 0);
            #1;
            checks++;
            if (s_ready !== exp_sready()) begin
                errors++; $display("FAIL starve_sready cyc=%0d got=%b want=%b", cyc, s_ready, exp_sready());
            end
            if (m_valid && (!busy || frame_done)) mv_idle = 1'b1;
            if (lb_wr_en) nin++;
            if (m_valid && m_ready) begin
                if (int'(win_row) * W + int'(win_col) != nout) order_ok = 1'b0;
                nout++;
            end
            if (nin - nout > max_lead) max_lead = nin - nout;
            if (frame_done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (max_lead > W + 2) begin
            errors++; $display("FAIL starve_lead got=%0d want<=%0d", max_lead, W + 2);
        end
        checks++;
        if (!order_ok || nout !== N || nin !== N) begin
            errors++; $display("FAIL starve_order ok=%b in=%0d out=%0d want 1 %0d %0d", order_ok, nin, nout, N, N);
        end
        checks++;
        if (mv_idle || ndone !== 1) begin
            errors++; $display("FAIL starve_idle mv_idle=%b done=%0d want 0 1", mv_idle, ndone);
        end
    endtask

    task automatic test_reset_mid;
        int nin = 0, nout = 0, ndone = 0;
        s_valid = 1'b1; m_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && nin < 9; cyc++) begin
            #1;
            if (lb_wr_en) nin++;
            @(negedge clk);
        end
        checks++;
        if (nin !== 9) begin
            errors++; $display("FAIL rmid_reach got=%0d want=9", nin);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, m_valid, lb_wr_en, frame_done, busy, bord_top, bord_bot, bord_lft, bord_rgt, win_row, win_col, lb_wr_col} !== 15'b0) begin
            errors++; $display("FAIL rmid_outputs got=%b want=0",
                {s_ready, m_valid, lb_wr_en, frame_done, busy, bord_top, bord_bot, bord_lft, bord_rgt, win_row, win_col, lb_wr_col});
        end
        @(negedge clk);
        rst = 1'b0;
        nin = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            if (frame_done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (ndone !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_no_done done=%0d busy=%b want 0 0", ndone, busy);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            #1;
            if (lb_wr_en) nin++;
            if (m_valid && m_ready) nout++;
            if (frame_done) ndone++;
            @(negedge clk);
        end
        checks++;
        if (nin !== N || nout !== N || ndone !== 1) begin
            errors++; $display("FAIL rmid_clean in=%0d out=%0d done=%0d want %0d %0d 1", nin, nout, ndone, N, N);
        end
    endtask

    task automatic test_start_busy;
        int nin = 0, nout = 0, ndone = 0, done_cyc = -1;
        s_valid = 1'b1; m_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            start = (cyc == 8);
            #1;
            if (lb_wr_en) nin++;
            if (m_valid && m_ready) nout++;
            if (frame_done) begin
                ndone++;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (nin !== N || nout !== N || ndone !== 1) begin
            errors++; $display("FAIL busy_start counts in=%0d out=%0d done=%0d want %0d %0d 1", nin, nout, ndone, N, N);
        end
        checks++;
        if (done_cyc !== basic_done_cyc) begin
            errors++; $display("FAIL busy_start timing done_at=%0d want=%0d", done_cyc, basic_done_cyc);
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 3; f++) begin
            bit seen = 1'b0;
            s_valid = 1'b0; m_ready = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
                s_valid = 1'($urandom_range(0, 1));
                m_ready = ($urandom_range(0, 3) != 0);
                #1;
                checks++;
                if ({s_ready, m_valid, lb_wr_en} !== {exp_sready(), exp_mvalid(), s_valid && exp_sready()}) begin
                    errors++; $display("FAIL rand_hs f=%0d cyc=%0d got=%b want=%b", f, cyc,
                        {s_ready, m_valid, lb_wr_en}, {exp_sready(), exp_mvalid(), s_valid && exp_sready()});
                end
                checks++;
                if ({frame_done, busy} !== {m_donef, m_act || m_donef}) begin
                    errors++; $display("FAIL rand_ctrl f=%0d cyc=%0d got=%b want=%b", f, cyc, {frame_done, busy}, {m_donef, m_act || m_donef});
                end
                if (exp_mvalid()) begin
                    checks++;
                    if (int'(win_row) != m_out / W || int'(win_col) != m_out % W ||
                        {bord_top, bord_bot, bord_lft, bord_rgt} !== {m_out / W == 0, m_out / W == H - 1, m_out % W == 0, m_out % W == W - 1}) begin
                        errors++; $display("FAIL rand_pos f=%0d cyc=%0d got row=%0d col=%0d flags=%b want idx=%0d", f, cyc,
                            win_row, win_col, {bord_top, bord_bot, bord_lft, bord_rgt}, m_out);
                    end
                end
                if (frame_done) seen = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (!seen) begin
                errors++; $display("FAIL rand_timeout f=%0d frame_done got=0 want=1", f);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        test_reset;
        test_basic;
        test_borders;
        test_backpressure;
        test_starved;
        test_reset_mid;
        test_start_busy;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
